// File: rtl/key_event_decoder_pkg.sv
// Shared key-event definitions: event polarity, default timing, decoder state encoding.
// Also imported by the key debounce filter.
package key_event_decoder_pkg;

  localparam logic KEY_DOWN = 1'b0;
  localparam logic KEY_UP   = 1'b1;

  localparam int DEF_LONG_CYC   = 75_000_000;
  localparam int DEF_REPEAT_CYC = 10_000_000;
  localparam int DEF_DCLICK_CYC = 15_000_000;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_PRESSED = 5'b00010,
    ST_HOLD    = 5'b00100,
    ST_WAIT2   = 5'b01000,
    ST_PRESS2  = 5'b10000
  } kev_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key events into short / double / long / auto-repeat pulses.
//   state      | meaning
//   ST_IDLE    | key up, nothing pending
//   ST_PRESSED | first press, timing toward long detect
//   ST_HOLD    | long press detected, emitting repeat ticks
//   ST_WAIT2   | released after short press, waiting for a second press
//   ST_PRESS2  | second press of a double click, waiting for release
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int LONG_CYC   = DEF_LONG_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC,
  parameter int DCLICK_CYC = DEF_DCLICK_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic rep_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(max3(LONG_CYC, REPEAT_CYC, DCLICK_CYC) + 1);

  kev_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             press, release_ev;
  logic             long_tc, rep_tc, dclk_tc;
  logic             cnt_clr, cnt_run;

  assign press      = key_flag & (key_state == KEY_DOWN);
  assign release_ev = key_flag & (key_state == KEY_UP);

  assign long_tc = (cnt == CNT_W'(LONG_CYC - 1));
  assign rep_tc  = (cnt == CNT_W'(REPEAT_CYC - 1));
  assign dclk_tc = (cnt == CNT_W'(DCLICK_CYC - 1));

  assign busy = (state != ST_IDLE);

  // Counter restarts on every state change and on each repeat tick.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_run = 1'b0;
    case (state)
      ST_IDLE:    cnt_clr = 1'b1;
      ST_PRESSED: begin cnt_clr = release_ev | long_tc; cnt_run = 1'b1; end
      ST_HOLD:    begin cnt_clr = release_ev | rep_tc;  cnt_run = 1'b1; end
      ST_WAIT2:   begin cnt_clr = press | dclk_tc;      cnt_run = 1'b1; end
      ST_PRESS2:  cnt_clr = release_ev;
      default:    cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      rep_pulse    <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      rep_pulse    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) state <= ST_PRESSED;
        end
        ST_PRESSED: begin
          if (release_ev) begin
            state <= ST_WAIT2;
          end else if (long_tc) begin
            state      <= ST_HOLD;
            long_pulse <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (release_ev) begin
            state <= ST_IDLE;
          end else if (rep_tc) begin
            rep_pulse <= 1'b1;
          end
        end
        ST_WAIT2: begin
          if (press) begin
            state <= ST_PRESS2;
          end else if (dclk_tc) begin
            state       <= ST_IDLE;
            short_pulse <= 1'b1;
          end
        end
        ST_PRESS2: begin
          if (release_ev) begin
            state        <= ST_IDLE;
            double_pulse <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: timestamp-based reference model, queued expectations.
module tb_key_event_decoder;

  localparam int LONG_CYC   = 20;
  localparam int REPEAT_CYC = 5;
  localparam int DCLICK_CYC = 8;

  localparam int MI = 0, MD = 1, MH = 2, MU = 3, MD2 = 4;
  localparam logic [3:0] K_SHORT = 4'b1000, K_DOUBLE = 4'b0100,
                         K_LONG  = 4'b0010, K_REP    = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic short_pulse, double_pulse, long_pulse, rep_pulse, busy;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } exp_t;

  exp_t pq[$];
  logic bq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_mode = MI;
  int   m_mark = 0;

  key_event_decoder #(
    .LONG_CYC  (LONG_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .DCLICK_CYC(DCLICK_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .rep_pulse   (rep_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: elapsed time since entering the current phase decides timeouts.
  task automatic model_step(input logic f, input logic s);
    int   n, el;
    logic pr, rl;
    n  = cyc + 1;
    el = n - m_mark;
    pr = f & !s;
    rl = f & s;
    case (m_mode)
      MI: if (pr) begin m_mode = MD; m_mark = n; end
      MD: begin
        if (rl) begin
          m_mode = MU; m_mark = n;
        end else if (el == LONG_CYC) begin
          pq.push_back('{n, K_LONG}); m_mode = MH; m_mark = n;
        end
      end
      MH: begin
        if (rl) m_mode = MI;
        else if (el % REPEAT_CYC == 0) pq.push_back('{n, K_REP});
      end
      MU: begin
        if (pr) begin
          m_mode = MD2; m_mark = n;
        end else if (el == DCLICK_CYC) begin
          pq.push_back('{n, K_SHORT}); m_mode = MI;
        end
      end
      default: begin
        if (rl) begin pq.push_back('{n, K_DOUBLE}); m_mode = MI; end
      end
    endcase
    bq.push_back(m_mode != MI);
  endtask

  task automatic step(input logic f, input logic s);
    @(negedge clk);
    key_flag  = f;
    key_state = s;
    model_step(f, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic press();   step(1'b1, 1'b0); endtask
  task automatic release_k(); step(1'b1, 1'b1); endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n  = 1'b0;
    m_mode = MI;
    #1;
    chk("reset_assert_outs", {short_pulse, double_pulse, long_pulse, rep_pulse, busy}, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_flag  = ~key_flag;
      key_state = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    key_flag = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("reset_release_outs", {short_pulse, double_pulse, long_pulse, rep_pulse, busy}, 0);
  endtask

  // Monitor: compares whenever the DUT pulses or an expectation falls due.
  initial begin
    logic [3:0] p;
    exp_t       e;
    forever begin
      @(posedge clk);
      #1;
      p = {short_pulse, double_pulse, long_pulse, rep_pulse};
      if (!rst_n) begin
        chk("in_reset_outs", {p, busy}, 0);
      end else begin
        if (pq.size() > 0 && pq[0].cyc <= cyc) begin
          e = pq.pop_front();
          chk("pulse_kind", p, e.kind);
        end else if (p != 0) begin
          chk("unexpected_pulse", p, 0);
        end
        if (bq.size() > 0) chk("busy", busy, bq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset(4);
    idle(3);

    // short click
    press(); idle(4); release_k(); idle(12);
    // double click
    press(); idle(2); release_k(); idle(3); press(); idle(1); release_k(); idle(12);
    // long + repeat, then release
    press(); idle(39); release_k(); idle(4);
    // release on long terminal-count edge
    press(); idle(LONG_CYC - 1); release_k(); idle(12);
    // press on WAIT2 timeout edge
    press(); idle(2); release_k(); idle(DCLICK_CYC - 1); press(); idle(3); release_k(); idle(4);
    // duplicate press while holding
    press(); idle(LONG_CYC + 6); press(); idle(12); release_k(); idle(3);
    // spurious release in WAIT2 is ignored
    press(); idle(1); release_k(); idle(2); release_k(); idle(10);
    // reset while in WAIT2
    press(); idle(2); release_k(); idle(3);
    apply_reset(2);
    idle(DCLICK_CYC + 3);

    // randomized events of random polarity and spacing
    for (int k = 0; k < 120; k++) begin
      idle($urandom_range(0, 3) == 0 ? $urandom_range(15, 45) : $urandom_range(0, 10));
      step(1'b1, 1'($urandom_range(0, 1)));
    end
    release_k();
    idle(DCLICK_CYC + 4);
    release_k();
    idle(DCLICK_CYC + 4);

    chk("drain_pending", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
